// File: rtl/round_sequencer_m_pkg.sv
// Shared definitions for the rounding sequencer and its helpers.
//   - Rounding mode encodings (2-bit; 2'b11 is reserved and truncates).
//   - FSM state encoding for the sequencer controller.
package round_sequencer_m_pkg;

  localparam logic [1:0] RM_TRUNC   = 2'b00;
  localparam logic [1:0] RM_NEG_INF = 2'b01;
  localparam logic [1:0] RM_POS_INF = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    INCR   = 3'd2,
    RENORM = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/round_sequencer_m_round_flag_logic.sv
// round_flag_logic: combinational round-up decision for directed rounding.
// Shared by the multiplier and adder/subtracter rounding paths.
// Ports:
//   or_bit     in  1  OR of all bits discarded below the significand LSB
//   sign       in  1  result sign (1 = negative)
//   mode       in  2  rounding mode
//   round_flag out 1  significand must be incremented by one LSB
module round_flag_logic
  import round_sequencer_m_pkg::*;
(
  input  logic       or_bit,
  input  logic       sign,
  input  logic [1:0] mode,
  output logic       round_flag
);

  // Directed rounding moves the magnitude away from zero only when the
  // direction matches the sign and something non-zero was discarded.
  always_comb begin
    round_flag = 1'b0;
    case (mode)
      RM_NEG_INF: round_flag = or_bit & sign;
      RM_POS_INF: round_flag = or_bit & ~sign;
      default:    round_flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/round_sequencer_m.sv
// round_sequencer_m: multi-cycle rounding controller for the FP multiplier.
// Captures a normalized significand/exponent, decides whether to round,
// increments through a registered adder step, renormalizes on carry-out
// and flags exponent overflow. Valid/ready handshake on both sides.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   in_valid_i/in_ready_o   operand handshake (ready only in IDLE)
//   sgf_i, exp_i      normalized significand (with hidden bit), biased exponent
//   round_bits_i      bits discarded below the significand LSB
//   sign_i            result sign
//   round_mode_i      rounding mode
//   out_valid_o/out_ready_i result handshake
//   sgf_o, exp_o      rounded significand, adjusted exponent
//   round_applied_o   an increment was performed
//   overflow_o        exponent saturated to all-ones by rounding
//   busy_o            controller not in IDLE
module round_sequencer_m
  import round_sequencer_m_pkg::*;
#(
  parameter int SW = 24,
  parameter int EW = 8,
  parameter int RW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [SW-1:0] sgf_i,
  input  logic [EW-1:0] exp_i,
  input  logic [RW-1:0] round_bits_i,
  input  logic          sign_i,
  input  logic [1:0]    round_mode_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [SW-1:0] sgf_o,
  output logic [EW-1:0] exp_o,
  output logic          round_applied_o,
  output logic          overflow_o,
  output logic          busy_o
);

  // One-LSB increment, widened so the carry-out is visible.
  function automatic logic [SW:0] incr_sgf(input logic [SW-1:0] s);
    return {1'b0, s} + {{SW{1'b0}}, 1'b1};
  endfunction

  // Rounding into or beyond the all-ones exponent saturates.
  function automatic logic exp_saturates(input logic [EW-1:0] e_old,
                                         input logic [EW-1:0] e_new);
    return (e_old == {EW{1'b1}}) || (e_new == {EW{1'b1}});
  endfunction

  state_t        state;
  logic [SW-1:0] sgf_r;
  logic [EW-1:0] exp_r;
  logic          sign_r;
  logic [1:0]    mode_r;
  logic          or_r;
  logic          applied_r;
  logic          ovf_r;

  logic          round_flag;
  logic [SW:0]   sum;
  logic [EW-1:0] exp_inc;

  round_flag_logic u_flag (
    .or_bit     (or_r),
    .sign       (sign_r),
    .mode       (mode_r),
    .round_flag (round_flag)
  );

  assign sum     = incr_sgf(sgf_r);
  assign exp_inc = exp_r + {{(EW-1){1'b0}}, 1'b1};

  assign in_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);

  // Working registers carry no reset: reset only returns control to IDLE
  // and clears the visible result, abandoning any operand in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      out_valid_o     <= 1'b0;
      sgf_o           <= '0;
      exp_o           <= '0;
      round_applied_o <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            sgf_r     <= sgf_i;
            exp_r     <= exp_i;
            sign_r    <= sign_i;
            mode_r    <= round_mode_i;
            or_r      <= |round_bits_i;
            applied_r <= 1'b0;
            ovf_r     <= 1'b0;
            state     <= DECIDE;
          end
        end
        DECIDE: begin
          state <= round_flag ? INCR : DONE;
        end
        INCR: begin
          applied_r <= 1'b1;
          if (sum[SW]) begin
            state <= RENORM;
          end else begin
            sgf_r <= sum[SW-1:0];
            state <= DONE;
          end
        end
        RENORM: begin
          // Carry-out means the significand was all ones: result is 1.000..
          if (exp_saturates(exp_r, exp_inc)) begin
            ovf_r <= 1'b1;
            exp_r <= {EW{1'b1}};
            sgf_r <= '0;
          end else begin
            exp_r <= exp_inc;
            sgf_r <= {1'b1, {(SW-1){1'b0}}};
          end
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; it is then held until
          // the downstream handshake completes.
          if (!out_valid_o) begin
            out_valid_o     <= 1'b1;
            sgf_o           <= sgf_r;
            exp_o           <= exp_r;
            round_applied_o <= applied_r;
            overflow_o      <= ovf_r;
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer_m.sv
// Scoreboard bench for round_sequencer_m: expected results are queued when
// an operand is driven and compared when the sequencer presents a result.
module tb_round_sequencer_m;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] sgf_in = '0;
  logic [7:0]  exp_in = '0;
  logic [23:0] rb_in = '0;
  logic        sign_in = 1'b0;
  logic [1:0]  mode_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] sgf_out;
  logic [7:0]  exp_out;
  logic        applied;
  logic        ovf;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [23:0] sgf;
    logic [7:0]  exp;
    logic        app;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  always #5 clk = ~clk;

  round_sequencer_m #(.SW(24), .EW(8), .RW(24)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .sgf_i           (sgf_in),
    .exp_i           (exp_in),
    .round_bits_i    (rb_in),
    .sign_i          (sign_in),
    .round_mode_i    (mode_in),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .sgf_o           (sgf_out),
    .exp_o           (exp_out),
    .round_applied_o (applied),
    .overflow_o      (ovf),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference behaviour of the rounding step, written from the mode table.
  function automatic exp_t model(input logic [23:0] s, input logic [7:0] e,
                                 input logic [23:0] rb, input logic sg,
                                 input logic [1:0] m);
    exp_t r;
    logic flag;
    logic [24:0] up;
    flag = (rb != 24'h0) && ((m == 2'b01 && sg) || (m == 2'b10 && !sg));
    r.sgf = s; r.exp = e; r.app = 1'b0; r.ovf = 1'b0; r.lat = 2;
    if (flag) begin
      up = {1'b0, s} + 25'd1;
      r.app = 1'b1;
      if (!up[24]) begin
        r.sgf = up[23:0];
        r.lat = 3;
      end else begin
        r.lat = 4;
        if (e == 8'hFF || e == 8'hFE) begin
          r.sgf = 24'h0; r.exp = 8'hFF; r.ovf = 1'b1;
        end else begin
          r.sgf = 24'h800000; r.exp = e + 8'd1;
        end
      end
    end
    return r;
  endfunction

  // Waits (bounded) for in_ready, drives one operand and returns after the
  // accepting clock edge. in_valid is still high on return.
  task automatic send(input logic [23:0] s, input logic [7:0] e, input logic [23:0] rb,
                      input logic sg, input logic [1:0] m, input bit push);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    sgf_in = s; exp_in = e; rb_in = rb; sign_in = sg; mode_in = m;
    in_valid = 1'b1;
    if (push) sb.push_back(model(s, e, rb, sg, m));
    @(posedge clk);
  endtask

  // Called right after an accepting edge; measures latency and compares.
  task automatic wait_result(input string tag);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      last_e = e;
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      chk({tag, "_sgf"}, {8'h0, sgf_out}, {8'h0, e.sgf});
      chk({tag, "_exp"}, {24'h0, exp_out}, {24'h0, e.exp});
      chk({tag, "_app"}, 32'(applied), 32'(e.app));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [23:0] s, input logic [7:0] e,
                     input logic [23:0] rb, input logic sg, input logic [1:0] m);
    send(s, e, rb, sg, m, 1'b1);
    wait_result(tag);
    release_out(tag);
  endtask

  initial begin
    logic [31:0] r;
    logic [23:0] rs, rr;
    logic [7:0]  re;
    bit          dropped;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sgf", {8'h0, sgf_out}, 32'h0);
    chk("rst_exp", {24'h0, exp_out}, 32'h0);
    rst = 1'b1;

    // Directed cases
    run("trunc",     24'h123456, 8'h85, 24'h000001, 1'b0, 2'b00);
    run("pinf_pos",  24'h123456, 8'h85, 24'h800000, 1'b0, 2'b10);
    run("pinf_neg",  24'h123456, 8'h85, 24'h800000, 1'b1, 2'b10);
    run("ninf_neg",  24'h123456, 8'h85, 24'h000100, 1'b1, 2'b01);
    run("ninf_zero", 24'h123456, 8'h85, 24'h000000, 1'b1, 2'b01);
    run("reserved",  24'h123456, 8'h85, 24'hFFFFFF, 1'b0, 2'b11);
    run("carry",     24'hFFFFFF, 8'h80, 24'h000001, 1'b1, 2'b01);
    run("overflow",  24'hFFFFFF, 8'hFE, 24'h000001, 1'b0, 2'b10);
    run("ovf_in_ff", 24'hFFFFFF, 8'hFF, 24'h000001, 1'b0, 2'b10);
    run("ff_pass",   24'hABCDEF, 8'hFF, 24'h000000, 1'b0, 2'b10);

    // out_ready held high before DONE: result still appears and lasts 1 cycle
    out_ready = 1'b1;
    send(24'h00FFFF, 8'h10, 24'h000002, 1'b0, 2'b10, 1'b1);
    wait_result("early_rdy");
    @(negedge clk);
    chk("early_rdy_pulse", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Backpressure: hold in DONE, second operand waits for the IDLE cycle
    send(24'h345678, 8'h40, 24'h000010, 1'b0, 2'b10, 1'b1);
    wait_result("bp1");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        sgf_in = 24'h0F0F0F; exp_in = 8'h22; rb_in = 24'h0; sign_in = 1'b0; mode_in = 2'b00;
        in_valid = 1'b1;
        sb.push_back(model(24'h0F0F0F, 8'h22, 24'h0, 1'b0, 2'b00));
      end
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_sgf", {8'h0, sgf_out}, {8'h0, last_e.sgf});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    @(posedge clk);
    wait_result("bp2");
    release_out("bp2");

    // Randomized operands, biased toward carry and exponent corner cases
    for (int k = 0; k < 10; k++) begin
      r = $urandom;  rs = r[23:0];
      if ($urandom_range(0, 2) == 0) rs = 24'hFFFFFF;
      r = $urandom;  re = r[7:0];
      if ($urandom_range(0, 3) == 0) re = 8'hFE;
      r = $urandom;  rr = $urandom_range(0, 1) == 0 ? 24'h0 : r[23:0];
      r = $urandom;
      run("rand", rs, re, rr, r[0], r[2:1]);
    end

    // Reset during INCR abandons the operand
    send(24'h000100, 8'h33, 24'h000004, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_sgf", {8'h0, sgf_out}, 32'h0);
    chk("mid_exp", {24'h0, exp_out}, 32'h0);
    chk("mid_app", 32'(applied), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_idle", 32'(busy), 32'd0);
    rst = 1'b1;
    dropped = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) dropped = 1'b0;
    end
    chk("mid_no_output", 32'(dropped), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
